// File: rtl/salsa_block_ctrl.sv
// Salsa20 keystream block controller: builds the initial state, iterates the external
// double-round core, applies the feed-forward sum and hands the block out on valid/ready.
module salsa_block_ctrl #(
   parameter int DOUBLE_ROUNDS = 10,
   parameter int DR_LAT        = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [255:0] key,
   input  logic [63:0]  nonce,
   input  logic [63:0]  ctr_init,
   input  logic         ctr_load,
   input  logic         start,
   output logic [511:0] dr_in,
   input  logic [511:0] dr_out,
   output logic [511:0] ks_block,
   output logic         ks_valid,
   input  logic         ks_ready,
   output logic         busy,
   output logic [63:0]  ctr
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_FEED  = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic [2:0] WAIT_LAST = 3'(DR_LAT - 1);
   localparam logic [3:0] RND_LAST  = 4'(DOUBLE_ROUNDS - 1);

   localparam logic [31:0] SIGMA0 = 32'h6170_7865;
   localparam logic [31:0] SIGMA1 = 32'h3320_646e;
   localparam logic [31:0] SIGMA2 = 32'h7962_2d32;
   localparam logic [31:0] SIGMA3 = 32'h6b20_6574;

   logic [1:0]   state;
   logic [3:0]   rnd;
   logic [2:0]   wait_cnt;
   logic [511:0] init_reg;
   logic [511:0] init_state;
   logic [511:0] ks_sum;

   // Word order w0..w15 runs from the MSB down; the counter enters low word first.
   assign init_state = {SIGMA0, key[255:128], SIGMA1, nonce,
                        ctr[31:0], ctr[63:32], SIGMA2, key[127:0], SIGMA3};

   assign busy = (state != S_IDLE);

   // NOTE: every output of an always_comb gets a default first so no latch is inferred.
   always_comb begin
      ks_sum = '0;
      for (int i = 0; i < 16; i++) begin
         ks_sum[511-32*i -: 32] = dr_in[511-32*i -: 32] + init_reg[511-32*i -: 32];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         rnd      <= '0;
         wait_cnt <= '0;
         init_reg <= '0;
         dr_in    <= '0;
         ks_block <= '0;
         ks_valid <= 1'b0;
         ctr      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ctr_load) begin
                  ctr <= ctr_init;
               end else if (start) begin
                  init_reg <= init_state;
                  dr_in    <= init_state;
                  rnd      <= '0;
                  wait_cnt <= '0;
                  state    <= S_ROUND;
               end
            end
            S_ROUND: begin
               // Capture the core result once it has had DR_LAT cycles to settle.
               if (wait_cnt == WAIT_LAST) begin
                  dr_in    <= dr_out;
                  wait_cnt <= '0;
                  rnd      <= rnd + 4'd1;
                  if (rnd == RND_LAST) state <= S_FEED;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            S_FEED: begin
               ks_block <= ks_sum;
               ks_valid <= 1'b1;
               state    <= S_OUT;
            end
            S_OUT: begin
               if (ks_ready) begin
                  ks_valid <= 1'b0;
                  ctr      <= ctr + 64'd1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_salsa_block_ctrl.sv
// Bench for salsa_block_ctrl: three parameterisations driven against a Salsa20 reference
// model, each with its own behavioural double-round core of the matching latency.
module tb_salsa_block_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] key;
   logic [63:0]  nonce;
   logic [63:0]  ctr_init;
   logic         start_s  [3];
   logic         load_s   [3];
   logic         ready_s  [3];
   logic [511:0] dr_in_s  [3];
   logic [511:0] dr_out_s [3];
   logic [511:0] ks_blk_s [3];
   logic         valid_s  [3];
   logic         busy_s   [3];
   logic [63:0]  ctr_s    [3];
   logic [511:0] pipe     [3][3];
   logic [63:0]  model_ctr [3];

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   function automatic int dr_of(input int i);
      return (i == 0) ? 10 : 1;
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 4;
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
      logic [31:0] a, b, c, d;
      a = a0; b = b0; c = c0; d = d0;
      b = b ^ rotl(a + d, 7);
      c = c ^ rotl(b + a, 9);
      d = d ^ rotl(c + b, 13);
      a = a ^ rotl(d + c, 18);
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] double_round(input logic [511:0] s);
      logic [31:0]  x [16];
      logic [511:0] r;
      for (int i = 0; i < 16; i++) x[i] = s[511-32*i -: 32];
      {x[0],  x[4],  x[8],  x[12]} = qr(x[0],  x[4],  x[8],  x[12]);
      {x[5],  x[9],  x[13], x[1]}  = qr(x[5],  x[9],  x[13], x[1]);
      {x[10], x[14], x[2],  x[6]}  = qr(x[10], x[14], x[2],  x[6]);
      {x[15], x[3],  x[7],  x[11]} = qr(x[15], x[3],  x[7],  x[11]);
      {x[0],  x[1],  x[2],  x[3]}  = qr(x[0],  x[1],  x[2],  x[3]);
      {x[5],  x[6],  x[7],  x[4]}  = qr(x[5],  x[6],  x[7],  x[4]);
      {x[10], x[11], x[8],  x[9]}  = qr(x[10], x[11], x[8],  x[9]);
      {x[15], x[12], x[13], x[14]} = qr(x[15], x[12], x[13], x[14]);
      r = '0;
      for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i];
      return r;
   endfunction

   function automatic logic [511:0] salsa_init(input logic [255:0] k, input logic [63:0] n,
                                               input logic [63:0] c);
      logic [31:0]  w [16];
      logic [511:0] r;
      w[0] = 32'h61707865; w[5] = 32'h3320646e; w[10] = 32'h79622d32; w[15] = 32'h6b206574;
      for (int j = 0; j < 4; j++) begin
         w[1+j]  = k[255-32*j -: 32];
         w[11+j] = k[127-32*j -: 32];
      end
      w[6] = n[63:32];
      w[7] = n[31:0];
      w[8] = c[31:0];
      w[9] = c[63:32];
      r = '0;
      for (int i = 0; i < 16; i++) r[511-32*i -: 32] = w[i];
      return r;
   endfunction

   function automatic logic [511:0] salsa_block(input logic [255:0] k, input logic [63:0] n,
                                                input logic [63:0] c, input int rounds);
      logic [511:0] s0, s;
      s0 = salsa_init(k, n, c);
      s  = s0;
      for (int r = 0; r < rounds; r++) s = double_round(s);
      for (int i = 0; i < 16; i++) s[511-32*i -: 32] = s[511-32*i -: 32] + s0[511-32*i -: 32];
      return s;
   endfunction

   // External double-round core model: result valid DR_LAT-1 edges after dr_in changes.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         pipe[i][0] <= dr_in_s[i];
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         dr_out_s[i] = double_round((lat_of(i) == 1) ? dr_in_s[i] : pipe[i][lat_of(i)-2]);
      end
   end

   salsa_block_ctrl #(.DOUBLE_ROUNDS(10), .DR_LAT(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .key(key), .nonce(nonce), .ctr_init(ctr_init),
      .ctr_load(load_s[0]), .start(start_s[0]), .dr_in(dr_in_s[0]), .dr_out(dr_out_s[0]),
      .ks_block(ks_blk_s[0]), .ks_valid(valid_s[0]), .ks_ready(ready_s[0]),
      .busy(busy_s[0]), .ctr(ctr_s[0]));

   salsa_block_ctrl #(.DOUBLE_ROUNDS(1), .DR_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .key(key), .nonce(nonce), .ctr_init(ctr_init),
      .ctr_load(load_s[1]), .start(start_s[1]), .dr_in(dr_in_s[1]), .dr_out(dr_out_s[1]),
      .ks_block(ks_blk_s[1]), .ks_valid(valid_s[1]), .ks_ready(ready_s[1]),
      .busy(busy_s[1]), .ctr(ctr_s[1]));

   salsa_block_ctrl #(.DOUBLE_ROUNDS(1), .DR_LAT(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .key(key), .nonce(nonce), .ctr_init(ctr_init),
      .ctr_load(load_s[2]), .start(start_s[2]), .dr_in(dr_in_s[2]), .dr_out(dr_out_s[2]),
      .ks_block(ks_blk_s[2]), .ks_valid(valid_s[2]), .ks_ready(ready_s[2]),
      .busy(busy_s[2]), .ctr(ctr_s[2]));

   task automatic randomize_inputs();
      for (int j = 0; j < 8; j++) key[255-32*j -: 32] = $urandom;
      nonce = {$urandom, $urandom};
   endtask

   // One full block on instance i; optional mid-block disturbance and ready back-pressure.
   task automatic run_block(input int i, input bit glitch, input int hold,
                            output logic [511:0] init_seen);
      logic [511:0] exp_blk, exp_init, held;
      logic [63:0]  c;
      int           cnt, exp_lat;
      bit           got;
      c        = model_ctr[i];
      exp_init = salsa_init(key, nonce, c);
      exp_blk  = salsa_block(key, nonce, c, dr_of(i));
      exp_lat  = 1 + dr_of(i) * lat_of(i);
      @(negedge clk) start_s[i] = 1'b1;
      @(posedge clk);
      @(negedge clk) start_s[i] = 1'b0;
      init_seen = dr_in_s[i];
      total_cnt++;
      if (dr_in_s[i] !== exp_init)
         $display("FAIL init_state[%0d]: got %h expected %h", i, dr_in_s[i], exp_init);
      else pass_cnt++;
      total_cnt++;
      if (busy_s[i] !== 1'b1) $display("FAIL busy_after_start[%0d]: got %b expected 1", i, busy_s[i]);
      else pass_cnt++;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 400) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (glitch && cnt == 2) begin
            start_s[i] = 1'b1;
            load_s[i]  = 1'b1;
            ctr_init   = {$urandom, $urandom};
            randomize_inputs();
         end else if (glitch && cnt == 3) begin
            start_s[i] = 1'b0;
            load_s[i]  = 1'b0;
         end
         got = valid_s[i];
      end
      start_s[i] = 1'b0;
      load_s[i]  = 1'b0;
      total_cnt++;
      if (!got || cnt != exp_lat)
         $display("FAIL latency[%0d]: got %0d edges (valid=%b) expected %0d", i, cnt, got, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (ks_blk_s[i] !== exp_blk)
         $display("FAIL ks_block[%0d]: got %h expected %h", i, ks_blk_s[i], exp_blk);
      else pass_cnt++;
      held = ks_blk_s[i];
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         total_cnt++;
         if ({valid_s[i], ks_blk_s[i], ctr_s[i]} !== {1'b1, held, c})
            $display("FAIL hold[%0d] cycle %0d: got valid=%b ctr=%h expected valid=1 ctr=%h",
                     i, h, valid_s[i], ctr_s[i], c);
         else pass_cnt++;
      end
      ready_s[i] = 1'b1;
      @(posedge clk);
      @(negedge clk) ready_s[i] = 1'b0;
      model_ctr[i] = c + 64'd1;
      total_cnt++;
      if ({valid_s[i], busy_s[i]} !== 2'b00)
         $display("FAIL after_handshake[%0d]: got valid=%b busy=%b expected 0 0", i, valid_s[i], busy_s[i]);
      else pass_cnt++;
      total_cnt++;
      if (ctr_s[i] !== model_ctr[i])
         $display("FAIL ctr_inc[%0d]: got %h expected %h", i, ctr_s[i], model_ctr[i]);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      #3;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if ({valid_s[i], busy_s[i], ctr_s[i], ks_blk_s[i], dr_in_s[i]} !== '0)
            $display("FAIL reset[%0d]: got valid=%b busy=%b ctr=%h expected all zero",
                     i, valid_s[i], busy_s[i], ctr_s[i]);
         else pass_cnt++;
         model_ctr[i] = '0;
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_zero_block();
      logic [511:0] seen;
      key   = '0;
      nonce = '0;
      run_block(0, 1'b0, 0, seen);
   endtask

   task automatic test_reset_mid_round();
      logic [511:0] seen;
      randomize_inputs();
      @(negedge clk) start_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk) start_s[0] = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({valid_s[0], busy_s[0], ctr_s[0]} !== '0)
         $display("FAIL reset_mid_round: got valid=%b busy=%b ctr=%h expected 0 0 0",
                  valid_s[0], busy_s[0], ctr_s[0]);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) model_ctr[i] = '0;
      @(negedge clk) rst_n = 1'b1;
      run_block(0, 1'b0, 0, seen);
   endtask

   task automatic test_backpressure();
      logic [511:0] seen;
      randomize_inputs();
      run_block(0, 1'b0, 5, seen);
   endtask

   task automatic test_ctr_wrap();
      logic [511:0] seen;
      randomize_inputs();
      @(negedge clk) begin
         ctr_init  = '1;
         load_s[0] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk) load_s[0] = 1'b0;
      total_cnt++;
      if ({busy_s[0], ctr_s[0]} !== {1'b0, 64'hffff_ffff_ffff_ffff})
         $display("FAIL ctr_load: got busy=%b ctr=%h expected 0 ffffffffffffffff", busy_s[0], ctr_s[0]);
      else pass_cnt++;
      model_ctr[0] = '1;
      run_block(0, 1'b0, 0, seen);
      total_cnt++;
      if ({seen[255:224], seen[223:192]} !== 64'hffff_ffff_ffff_ffff)
         $display("FAIL ctr_words_w8_w9: got %h expected ffffffffffffffff", {seen[255:224], seen[223:192]});
      else pass_cnt++;
      total_cnt++;
      if (ctr_s[0] !== 64'd0) $display("FAIL ctr_wrap: got %h expected 0", ctr_s[0]);
      else pass_cnt++;
   endtask

   task automatic test_ignored_controls();
      logic [511:0] seen;
      logic [63:0]  r;
      randomize_inputs();
      run_block(0, 1'b1, 1, seen);
      r = {$urandom, $urandom};
      @(negedge clk) begin
         ctr_init   = r;
         load_s[0]  = 1'b1;
         start_s[0] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk) begin
         load_s[0]  = 1'b0;
         start_s[0] = 1'b0;
      end
      model_ctr[0] = r;
      total_cnt++;
      if ({busy_s[0], ctr_s[0]} !== {1'b0, r})
         $display("FAIL load_and_start: got busy=%b ctr=%h expected 0 %h", busy_s[0], ctr_s[0], r);
      else pass_cnt++;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({busy_s[0], valid_s[0]} !== 2'b00)
         $display("FAIL idle_stays_idle: got busy=%b valid=%b expected 0 0", busy_s[0], valid_s[0]);
      else pass_cnt++;
      randomize_inputs();
      run_block(0, 1'b0, 0, seen);
   endtask

   task automatic test_sweep();
      logic [511:0] seen;
      for (int n = 0; n < 4; n++) begin
         randomize_inputs();
         run_block(1 + (n % 2), 1'b0, n / 2, seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] seen;
      for (int n = 0; n < 3; n++) begin
         randomize_inputs();
         run_block(0, n[0], int'($urandom_range(0, 2)), seen);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      key      = '0;
      nonce    = '0;
      ctr_init = '0;
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b0;
         load_s[i]  = 1'b0;
         ready_s[i] = 1'b0;
      end
      test_reset();
      test_zero_block();
      test_reset_mid_round();
      test_backpressure();
      test_ctr_wrap();
      test_ignored_controls();
      test_sweep();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
